uart_mmio_port: RTL and testbench

- Memory-mapped UART peripheral for the jacaranda-8 data bus.
- Parametrised successor to the fixed three-address UART hookup: configurable base address, bit period and FIFO depths, with TX/RX FIFOs and sticky error flags.
- Sits beside data_mem on the CPU store/load path; the top level muxes r_data in when sel=1.

---
 rtl/uart_mmio_port.sv | 171 +++++++++++++++++
 tb/tb_uart_mmio_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_port.sv
// uart_mmio_port: memory-mapped UART with TX/RX FIFOs and sticky errors; define UART_LOOPBACK_EN for CTRL[3] loopback
module uart_mmio_port #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(252),
    parameter int                CLK_DIV   = 16,
    parameter int                TX_DEPTH  = 4,
    parameter int                RX_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        w_data,
    input  logic              w_en,
    input  logic              r_en,
    output logic [7:0]        r_data,
    output logic              sel,
    input  logic              rx,
    output logic              tx
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2 - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic [ADDR_W-1:0] off_full;
    logic [1:0] off;
    logic wr_tx, wr_ctrl, clr, tx_en, rx_en, loopback;
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;
    logic [RAW:0] rx_wp, rx_rp;
    logic tx_empty, tx_full, tx_push, rx_empty, rx_full, rx_pop, rx_wr, ovf_set;
    state_t tx_st, tx_nx, rx_st, rx_nx;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0] tx_bit_i, rx_bit_i;
    logic [7:0] tx_byte, rx_shift, rx_head, status, ctrl_rd;
    logic tx_tick, tx_go, tx_load, tx_line, tx_q, tx_busy;
    logic rx_s1, rx_s2, rx_prev, rx_in, rx_fall, rx_tick, rx_done, rx_push, ferr_set;
    logic rx_overflow, frame_err;
    assign off_full = addr - BASE_ADDR;
    assign sel = off_full[ADDR_W-1:2] == '0;
    assign off = off_full[1:0];
    assign wr_tx = w_en && sel && off == 2'd1;
    assign wr_ctrl = w_en && sel && off == 2'd3;
    assign clr = wr_ctrl && w_data[2];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_en <= 1'b0;
            rx_en <= 1'b0;
        end else if (wr_ctrl) begin
            tx_en <= w_data[0];
            rx_en <= w_data[1];
        end
    end
`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            loopback <= 1'b0;
        else if (wr_ctrl)
            loopback <= w_data[3];
    end
`else
    assign loopback = 1'b0;
`endif
    assign tx_empty = tx_wp == tx_rp;
    assign tx_full = tx_wp == {~tx_rp[TAW], tx_rp[TAW-1:0]};
    assign tx_push = wr_tx && !tx_full;
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full = rx_wp == {~rx_rp[RAW], rx_rp[RAW-1:0]};
    assign rx_pop = r_en && sel && off == 2'd0 && !rx_empty;
    assign rx_wr = rx_push && (!rx_full || rx_pop);
    assign ovf_set = rx_push && rx_full && !rx_pop;
    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wp[TAW-1:0]] <= w_data;
        if (rx_wr)
            rx_mem[rx_wp[RAW-1:0]] <= rx_shift;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_overflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_wp <= tx_push ? tx_wp + 1'b1 : tx_wp;
            tx_rp <= tx_load ? tx_rp + 1'b1 : tx_rp;
            rx_wp <= rx_wr ? rx_wp + 1'b1 : rx_wp;
            rx_rp <= rx_pop ? rx_rp + 1'b1 : rx_rp;
            rx_overflow <= ovf_set || (rx_overflow && !clr);
            frame_err <= ferr_set || (frame_err && !clr);
        end
    end
    assign tx_tick = tx_cnt == FULL_CNT;
    assign tx_go = tx_en && !tx_empty;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_st <= IDLE;
            tx_cnt <= '0;
            tx_bit_i <= '0;
            tx_byte <= '0;
            tx_q <= 1'b1;
        end else begin
            tx_st <= tx_nx;
            tx_cnt <= (tx_st == IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            tx_bit_i <= (tx_st == DATA && tx_tick) ? tx_bit_i + 1'b1 : tx_bit_i;
            tx_byte <= tx_load ? tx_mem[tx_rp[TAW-1:0]] : tx_byte;
            tx_q <= tx_line;
        end
    end
    always_comb begin
        tx_nx = tx_st == IDLE ? (tx_go ? START : IDLE)
              : !tx_tick ? tx_st
              : tx_st == START ? DATA
              : tx_st == DATA ? (tx_bit_i == 3'd7 ? STOP : DATA)
              : tx_go ? START : IDLE;
    end
    always_comb begin
        tx_load = tx_go && (tx_st == IDLE || (tx_st == STOP && tx_tick));
        tx_line = tx_st == START ? 1'b0 : tx_st == DATA ? tx_byte[tx_bit_i] : 1'b1;
    end
    assign tx_busy = !tx_empty || tx_st != IDLE;
    assign tx = loopback ? 1'b1 : tx_q;
    // loopback taps the registered TX line directly, skipping the synchroniser
    assign rx_in = loopback ? tx_q : rx_s2;
    assign rx_fall = rx_prev && !rx_in;
    assign rx_tick = rx_cnt == (rx_st == START ? HALF_CNT : FULL_CNT);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_prev <= 1'b1;
            rx_st <= IDLE;
            rx_cnt <= '0;
            rx_bit_i <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_prev <= rx_in;
            rx_st <= rx_nx;
            rx_cnt <= (rx_st == IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            rx_bit_i <= rx_st != DATA ? '0 : rx_tick ? rx_bit_i + 1'b1 : rx_bit_i;
            rx_shift <= (rx_st == DATA && rx_tick) ? {rx_in, rx_shift[7:1]} : rx_shift;
        end
    end
    always_comb begin
        rx_nx = !rx_en ? IDLE
              : rx_st == IDLE ? (rx_fall ? START : IDLE)
              : !rx_tick ? rx_st
              : rx_st == START ? (rx_in ? IDLE : DATA)
              : rx_st == DATA ? (rx_bit_i == 3'd7 ? STOP : DATA)
              : IDLE;
    end
    always_comb begin
        rx_done = rx_en && rx_st == STOP && rx_tick;
        rx_push = rx_done && rx_in;
        ferr_set = rx_done && !rx_in;
    end
    assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rp[RAW-1:0]];
    assign status = {3'b000, frame_err, rx_overflow, tx_full, !rx_empty, tx_busy};
    assign ctrl_rd = {4'b0000, loopback, 1'b0, rx_en, tx_en};
    assign r_data = !sel ? 8'h00
                  : off == 2'd0 ? rx_head
                  : off == 2'd2 ? status
                  : off == 2'd3 ? ctrl_rd
                  : 8'h00;
endmodule

// File: tb/tb_uart_mmio_port.sv
// tb_uart_mmio_port: randomized bench for uart_mmio_port against a queue-based UART model
module tb_uart_mmio_port;
    localparam logic [7:0] RXD = 8'd252;
    localparam logic [7:0] TXD = 8'd253;
    localparam logic [7:0] STA = 8'd254;
    localparam logic [7:0] CTL = 8'd255;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] w_data = 8'h00;
    logic w_en = 1'b0;
    logic r_en = 1'b0;
    logic rx = 1'b1;
    logic [7:0] r_data;
    logic sel, tx;
    int tests = 0;
    int fails = 0;
    logic [7:0] tx_got[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic ovf_m = 1'b0;
    logic ferr_m = 1'b0;

    uart_mmio_port #(.ADDR_W(8), .BASE_ADDR(8'd252), .CLK_DIV(4), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .addr(addr), .w_data(w_data), .w_en(w_en),
        .r_en(r_en), .r_data(r_data), .sel(sel), .rx(rx), .tx(tx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        addr = a;
        w_data = d;
        w_en = 1'b1;
        @(negedge clock);
        w_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic pop, output logic [7:0] d);
        @(negedge clock);
        addr = a;
        r_en = pop;
        #1 d = r_data;
        @(negedge clock);
        r_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] val, input logic stop);
        logic [9:0] f;
        f = {stop, val, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (4) @(negedge clock);
        end
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic model_rx(input logic [7:0] val, input logic stop);
        if (!stop) ferr_m = 1'b1;
        else if (rx_exp.size() < 4) rx_exp.push_back(val);
        else ovf_m = 1'b1;
    endtask

    function automatic logic [7:0] rx_status();
        return {3'b000, ferr_m, ovf_m, 1'b0, rx_exp.size() != 0, 1'b0};
    endfunction

    // serial level k cycles after the TXDATA write edge: idle, start, 8 data LSB first, stop
    function automatic logic frame_bit(input int k, input logic [7:0] val);
        if (k < 2 || k >= 38) return 1'b1;
        if (k < 6) return 1'b0;
        return val[3'((k - 6) / 4)];
    endfunction

    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin
                repeat (6) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    v[i] = tx;
                    if (i < 7) repeat (4) @(negedge clock);
                end
                repeat (4) @(negedge clock);
                tx_got.push_back(v);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, b, e;
        logic low_seen;
        repeat (3) @(negedge clock);
        check("tx_in_reset", 32'(tx), 32'(1));
        reset_n = 1'b1;
        bus_read(STA, 1'b0, d);
        check("status_rst", 32'(d), 32'(0));
        bus_read(CTL, 1'b0, d);
        check("ctrl_rst", 32'(d), 32'(0));
        bus_read(RXD, 1'b1, d);
        check("rxdata_empty", 32'(d), 32'(0));
        addr = 8'd251;
        #1 check("sel_below", 32'(sel), 32'(0));
        check("rdata_unsel", 32'(r_data), 32'(0));
        addr = RXD;
        #1 check("sel_base", 32'(sel), 32'(1));

        bus_write(CTL, 8'h01);
        b = 8'hA5;
        bus_write(TXD, b);
        addr = STA;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clock);
            check($sformatf("tx_k%0d", k), 32'(tx), 32'(frame_bit(k, b)));
            if (k <= 36) check("busy_in_frame", 32'(r_data[0]), 32'(1));
        end
        repeat (4) @(negedge clock);
        bus_read(STA, 1'b0, d);
        check("busy_after", 32'(d), 32'(0));
        check("tx_mon_count", 32'(tx_got.size()), 32'(1));
        d = tx_got.size() != 0 ? tx_got.pop_front() : 8'h00;
        check("tx_mon_byte", 32'(d), 32'(b));

        bus_write(CTL, 8'h00);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            bus_write(TXD, b);
            if (tx_exp.size() < 4) tx_exp.push_back(b);
            bus_read(STA, 1'b0, d);
            check("tx_full", 32'(d[2]), 32'(tx_exp.size() == 4));
        end
        bus_write(CTL, 8'h01);
        repeat (220) @(negedge clock);
        check("tx_frames", 32'(tx_got.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            d = tx_got.size() != 0 ? tx_got.pop_front() : ~tx_exp[i];
            check("tx_fifo_byte", 32'(d), 32'(tx_exp[i]));
        end
        bus_read(STA, 1'b0, d);
        check("status_tx_done", 32'(d), 32'(0));

        bus_write(CTL, 8'h02);
        b = 8'h3C;
        send_rx(b, 1'b1);
        model_rx(b, 1'b1);
        bus_read(STA, 1'b0, d);
        check("rx_avail", 32'(d), 32'(rx_status()));
        bus_read(RXD, 1'b1, d);
        check("rx_pop", 32'(d), 32'(rx_exp.pop_front()));
        bus_read(STA, 1'b0, d);
        check("rx_avail_clr", 32'(d), 32'(rx_status()));

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            model_rx(b, 1'b1);
        end
        bus_read(STA, 1'b0, d);
        check("rx_overflow", 32'(d), 32'(rx_status()));
        b = 8'($urandom);
        send_rx(b, 1'b0);
        model_rx(b, 1'b0);
        bus_read(STA, 1'b0, d);
        check("frame_err", 32'(d), 32'(rx_status()));
        bus_write(CTL, 8'h06);
        ovf_m = 1'b0;
        ferr_m = 1'b0;
        bus_read(STA, 1'b0, d);
        check("flags_clr", 32'(d), 32'(rx_status()));
        bus_read(CTL, 1'b0, d);
        check("ctrl_clr_reads0", 32'(d), 32'(8'h02));
        while (rx_exp.size() != 0) begin
            bus_read(RXD, 1'b1, d);
            check("rx_drain", 32'(d), 32'(rx_exp.pop_front()));
        end
        bus_read(RXD, 1'b1, d);
        check("rx_empty_read", 32'(d), 32'(0));

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                b = 8'($urandom);
                e = 8'($urandom_range(0, 7) != 0);
                send_rx(b, e[0]);
                model_rx(b, e[0]);
            end else begin
                bus_read(RXD, 1'b1, d);
                e = rx_exp.size() != 0 ? rx_exp.pop_front() : 8'h00;
                check("rx_rand_pop", 32'(d), 32'(e));
            end
            bus_read(STA, 1'b0, d);
            check("rx_rand_status", 32'(d), 32'(rx_status()));
        end
        while (rx_exp.size() != 0) begin
            bus_read(RXD, 1'b1, d);
            check("rx_rand_drain", 32'(d), 32'(rx_exp.pop_front()));
        end

        fork
            send_rx(8'($urandom), 1'b1);
            begin
                repeat (20) @(negedge clock);
                bus_write(CTL, 8'h00);
            end
        join
        bus_write(CTL, 8'h02);
        b = 8'($urandom);
        send_rx(b, 1'b1);
        model_rx(b, 1'b1);
        bus_read(RXD, 1'b1, d);
        check("rx_after_abort", 32'(d), 32'(rx_exp.pop_front()));
        bus_read(STA, 1'b1, d);
        check("rx_abort_status", 32'(d[1]), 32'(0));

        bus_write(CTL, 8'h0B);
        bus_read(CTL, 1'b0, d);
`ifdef UART_LOOPBACK_EN
        check("ctrl_loopback", 32'(d), 32'(8'h0B));
        bus_write(TXD, 8'h5A);
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("lb_tx_held", 32'(low_seen), 32'(0));
        bus_read(RXD, 1'b1, d);
        check("lb_rx_byte", 32'(d), 32'(8'h5A));
        bus_write(CTL, 8'h03);
`else
        check("ctrl_bit3_ignored", 32'(d), 32'(8'h03));
        low_seen = 1'b0;
`endif

        bus_write(CTL, 8'h01);
        bus_write(TXD, 8'($urandom));
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1 check("tx_reset_abort", 32'(tx), 32'(1));
        addr = STA;
        #1 check("status_in_reset", 32'(r_data), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;
        bus_read(CTL, 1'b0, d);
        check("ctrl_after_reset", 32'(d), 32'(0));
        low_seen = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("tx_idle_after_reset", 32'(low_seen), 32'(0));
        tx_got.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
